// File: rtl/hier_child_sequencer.sv
// Drives N_CHILD child blocks one after another: strobe child idx, wait for its done, advance.
// Ends with a one-cycle done pulse, flagged as an error with the child index if a child times out.
module hier_child_sequencer #(
    parameter  int N_CHILD = 5,
    parameter  int TIMEOUT = 16,
    localparam int IDX_W   = (N_CHILD > 1) ? $clog2(N_CHILD) : 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start_i,
    output logic               busy_o,
    output logic               done_o,
    output logic               err_o,
    output logic [IDX_W-1:0]   err_idx_o,
    output logic [N_CHILD-1:0] child_start_o,
    input  logic [N_CHILD-1:0] child_done_i
);
    // Wide enough to hold TIMEOUT-1; the counter stops there, so it never wraps.
    localparam int CNT_W = $clog2(TIMEOUT) + 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_CHILD - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LAUNCH,
        S_WAIT,
        S_DONE,
        S_ERR
    } state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               err_q, err_d;
    logic [IDX_W-1:0]   err_idx_q, err_idx_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [N_CHILD-1:0] strobe_q, strobe_d;
    logic               cur_done;

    always_comb begin
        cur_done  = child_done_i[idx_q];
        state_d   = state_q;
        idx_d     = idx_q;
        cnt_d     = cnt_q;
        err_d     = err_q;
        err_idx_d = err_idx_q;

        unique case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    state_d   = S_LAUNCH;
                    idx_d     = '0;
                    err_d     = 1'b0;
                    err_idx_d = '0;
                end
            end
            S_LAUNCH: begin
                state_d = S_WAIT;
                cnt_d   = '0;
            end
            S_WAIT: begin
                // A done arriving in the final allowed cycle still counts as success.
                if (cur_done) begin
                    if (idx_q == LAST_IDX) begin
                        state_d = S_DONE;
                    end else begin
                        idx_d   = idx_q + IDX_W'(1);
                        state_d = S_LAUNCH;
                    end
                end else if (cnt_q == CNT_LAST) begin
                    state_d   = S_ERR;
                    err_d     = 1'b1;
                    err_idx_d = idx_q;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_DONE, S_ERR: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Outputs are precomputed from the next state so they leave straight from flops.
        busy_d   = (state_d != S_IDLE);
        done_d   = (state_d == S_DONE) || (state_d == S_ERR);
        strobe_d = '0;
        if (state_d == S_LAUNCH) begin
            strobe_d[idx_d] = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            idx_q     <= '0;
            cnt_q     <= '0;
            err_q     <= 1'b0;
            err_idx_q <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            strobe_q  <= '0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            cnt_q     <= cnt_d;
            err_q     <= err_d;
            err_idx_q <= err_idx_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            strobe_q  <= strobe_d;
        end
    end

    assign busy_o        = busy_q;
    assign done_o        = done_q;
    assign err_o         = err_q;
    assign err_idx_o     = err_idx_q;
    assign child_start_o = strobe_q;

endmodule

// File: tb/tb_hier_child_sequencer.sv
// Bench for hier_child_sequencer: a cycle-timeline model checked every cycle,
// plus directed runs whose strobe/done timing is pinned to hand-computed cycle offsets.
module tb_hier_child_sequencer;
    localparam int N_CHILD = 5;
    localparam int TIMEOUT = 16;
    localparam int IDX_W   = 3;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               start_i = 1'b0;
    logic               busy_o;
    logic               done_o;
    logic               err_o;
    logic [IDX_W-1:0]   err_idx_o;
    logic [N_CHILD-1:0] child_start_o;
    logic [N_CHILD-1:0] child_done_i;

    hier_child_sequencer #(.N_CHILD(N_CHILD), .TIMEOUT(TIMEOUT)) dut (
        .clk          (clk),
        .rst          (rst),
        .start_i      (start_i),
        .busy_o       (busy_o),
        .done_o       (done_o),
        .err_o        (err_o),
        .err_idx_o    (err_idx_o),
        .child_start_o(child_start_o),
        .child_done_i (child_done_i)
    );

    always #5 clk = ~clk;

    int compared   = 0;
    int mismatched = 0;
    int cyc        = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_output(input string name, input int actual, input int expected);
        compared++;
        if (actual != expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0d, want %0d (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    // Model: tracks the run as cycle numbers (strobe cycle of the current child, end cycle).
    int m_active  = 0;
    int m_child   = 0;
    int m_launch  = -10;
    int m_end     = -10;
    int m_err     = 0;
    int m_err_idx = 0;

    initial begin
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                m_active = 0; m_child = 0; m_launch = -10; m_end = -10;
                m_err = 0; m_err_idx = 0;
            end else if (m_active != 0) begin
                if (cyc == m_end) begin
                    m_active = 0;
                end else if (m_end < 0 && cyc > m_launch) begin
                    if (child_done_i[m_child]) begin
                        if (m_child == N_CHILD - 1) begin
                            m_end = cyc + 1;
                        end else begin
                            m_child  = m_child + 1;
                            m_launch = cyc + 1;
                        end
                    end else if (cyc - m_launch == TIMEOUT) begin
                        m_end     = cyc + 1;
                        m_err     = 1;
                        m_err_idx = m_child;
                    end
                end
            end else if (start_i) begin
                m_active = 1; m_child = 0; m_launch = cyc + 1; m_end = -10;
                m_err = 0; m_err_idx = 0;
            end
        end
    end

    int done_count = 0;
    int strobe_cyc[$];
    int strobe_val[$];

    always @(negedge clk) begin
        if (!rst) begin
            check_output("busy", busy_o, m_active);
            check_output("done", done_o, (m_active != 0 && cyc == m_end) ? 1 : 0);
            check_output("err", err_o, m_err);
            check_output("err_idx", err_idx_o, m_err_idx);
            check_output("strobe", child_start_o,
                         (m_active != 0 && cyc == m_launch) ? (1 << m_child) : 0);
            if (done_o) done_count++;
            if (child_start_o != '0) begin
                strobe_cyc.push_back(cyc);
                strobe_val.push_back(int'(child_start_o));
            end
        end
    end

    // Child responders: child i pulses done k_cfg[i] cycles after its strobe (0 = never).
    int   k_cfg[N_CHILD];
    int   rcnt[N_CHILD];
    bit   armed[N_CHILD];
    bit   hold_all = 1'b0;
    logic [N_CHILD-1:0] done_v;

    initial begin
        child_done_i = '0;
        forever begin
            @(posedge clk);
            #1;
            for (int i = 0; i < N_CHILD; i++) begin
                if (rst) begin
                    armed[i] = 1'b0;
                end else if (child_start_o[i]) begin
                    armed[i] = 1'b1;
                    rcnt[i]  = 0;
                end else if (armed[i]) begin
                    rcnt[i]++;
                end
                done_v[i] = armed[i] && k_cfg[i] > 0 && rcnt[i] == k_cfg[i];
                if (done_v[i]) armed[i] = 1'b0;
            end
            child_done_i = hold_all ? '1 : done_v;
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic apply_stimulus(output int c0);
        strobe_cyc.delete();
        strobe_val.delete();
        start_i = 1'b1;
        c0 = cyc;
        step(1);
        start_i = 1'b0;
    endtask

    task automatic wait_done(input string name, input int bound);
        int n = 0;
        while (!done_o && n < bound) begin
            step(1);
            n++;
        end
        check_output({name, "_done_seen"}, done_o, 1);
    endtask

    task automatic set_k(input int k);
        for (int i = 0; i < N_CHILD; i++) k_cfg[i] = k;
    endtask

    int c0;
    int base;
    int exp_cyc[5] = '{1, 5, 9, 13, 17};

    initial begin
        #10000000;
        $display("[TB] FAIL watchdog: simulation did not finish, got hang, want finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        set_k(3);
        step(3);
        check_output("rst_busy", busy_o, 0);
        check_output("rst_done", done_o, 0);
        check_output("rst_err", err_o, 0);
        check_output("rst_err_idx", err_idx_o, 0);
        check_output("rst_strobe", child_start_o, 0);
        rst = 1'b0;
        step(2);

        $display("[TB] default sequence, every child answers after 3 cycles");
        apply_stimulus(c0);
        wait_done("seq", 60);
        check_output("seq_done_cycle", cyc - c0, 21);
        check_output("seq_err", err_o, 0);
        check_output("seq_strobes", strobe_cyc.size(), 5);
        for (int i = 0; i < 5; i++) begin
            check_output($sformatf("seq_strobe%0d_cycle", i), strobe_cyc[i] - c0, exp_cyc[i]);
            check_output($sformatf("seq_strobe%0d_val", i), strobe_val[i], 1 << i);
        end
        step(2);

        $display("[TB] reset while waiting on child 2");
        apply_stimulus(c0);
        begin
            int n = 0;
            while (strobe_cyc.size() < 3 && n < 40) begin
                step(1);
                n++;
            end
        end
        check_output("abort_reached_child2", strobe_cyc.size(), 3);
        step(1);
        rst = 1'b1;
        #1;
        check_output("abort_busy", busy_o, 0);
        check_output("abort_strobe", child_start_o, 0);
        check_output("abort_err", err_o, 0);
        base = done_count;
        step(2);
        rst = 1'b0;
        step(30);
        check_output("abort_no_done", done_count - base, 0);
        apply_stimulus(c0);
        check_output("abort_restart_child0", child_start_o, 1);
        wait_done("abort_restart", 60);
        step(2);

        $display("[TB] child 3 never answers");
        set_k(1);
        k_cfg[3] = 0;
        apply_stimulus(c0);
        wait_done("tmo", 80);
        check_output("tmo_done_cycle", cyc - c0, 24);
        check_output("tmo_err", err_o, 1);
        check_output("tmo_err_idx", err_idx_o, 3);
        step(10);
        check_output("tmo_hold_err", err_o, 1);
        check_output("tmo_hold_idx", err_idx_o, 3);
        check_output("tmo_no_child4", strobe_cyc.size(), 4);

        $display("[TB] all done inputs held high");
        hold_all = 1'b1;
        apply_stimulus(c0);
        wait_done("hold", 40);
        check_output("hold_done_cycle", cyc - c0, 11);
        check_output("hold_strobes", strobe_cyc.size(), 5);
        check_output("hold_strobe4_cycle", strobe_cyc[4] - c0, 9);
        check_output("hold_err_cleared", err_o, 0);
        hold_all = 1'b0;
        step(2);

        $display("[TB] child 0 answers in its last allowed wait cycle");
        set_k(1);
        k_cfg[0] = TIMEOUT;
        apply_stimulus(c0);
        wait_done("edge", 80);
        check_output("edge_err", err_o, 0);
        check_output("edge_done_cycle", cyc - c0, 26);
        check_output("edge_child1_cycle", strobe_cyc[1] - c0, 18);
        step(2);

        $display("[TB] error run, then restart with stray start pulses");
        set_k(2);
        k_cfg[1] = 0;
        apply_stimulus(c0);
        wait_done("prior", 80);
        check_output("prior_done_cycle", cyc - c0, 21);
        check_output("prior_err_idx", err_idx_o, 1);
        step(2);
        k_cfg[1] = 2;
        base = done_count;
        apply_stimulus(c0);
        check_output("restart_err_cleared", err_o, 0);
        check_output("restart_idx_cleared", err_idx_o, 0);
        step(2);
        start_i = 1'b1;
        step(3);
        start_i = 1'b0;
        wait_done("restart", 60);
        check_output("restart_done_cycle", cyc - c0, 16);
        start_i = 1'b1;
        step(1);
        start_i = 1'b0;
        step(5);
        check_output("restart_idle", busy_o, 0);
        check_output("restart_one_done", done_count - base, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/hier_child_sequencer.md
Name: hier_child_sequencer

Overview:
Sequencing controller that sits directly upstream of a hierarchy node's child instances and drives them in order.
- On a start request it launches child 0 with a one-cycle start strobe and waits for that child's done.
- It then launches child 1, and so on up to child N_CHILD-1.
- It reports completion, or a timeout error together with the index of the child that failed to answer.

Parameters:
N_CHILD, 5, number of child instances driven (>=1)
TIMEOUT, 16, maximum WAIT cycles allowed per child before error (>=1)
IDX_W, $clog2(N_CHILD) (min 1), derived localparam; width of child index

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  asynchronous, active-high reset
start_i  input  1  request a full sequence; sampled only in IDLE
busy_o  output  1  high whenever state != IDLE
done_o  output  1  one-cycle pulse at end of sequence (success or error)
err_o  output  1  valid with done_o; 1 = a child timed out
err_idx_o  output  IDX_W  index of the timed-out child; held until next accepted start
child_start_o  output  N_CHILD  one-hot start strobe to children
child_done_i  input  N_CHILD  per-child done, level or pulse

Behaviour:
- Interface: one clock; reset is asynchronous and active-high.
- Reset: state=IDLE, idx=0, wait counter=0. All outputs are 0: busy_o, done_o, err_o, err_idx_o, child_start_o.
- Reset asserted mid-sequence aborts immediately. No done_o is issued for the aborted sequence.
- All outputs are registered or decoded from registered state only. There are no combinational paths from inputs to outputs.
- States and transitions:
  - IDLE:
    - start_i=1 -> LAUNCH with idx=0; err_o and err_idx_o cleared.
    - otherwise stay in IDLE.
  - LAUNCH (1 cycle):
    - child_start_o[idx]=1; all other bits are 0.
    - wait counter cleared.
    - -> WAIT unconditionally.
    - child_done_i is ignored in this cycle.
  - WAIT:
    - child_done_i[idx]=1 and idx==N_CHILD-1 -> DONE.
    - child_done_i[idx]=1 and idx<N_CHILD-1 -> idx+1, go to LAUNCH.
    - else if counter==TIMEOUT-1 -> ERR.
    - else counter+1.
    - Done takes priority over timeout in the same cycle.
  - DONE (1 cycle): done_o=1, err_o=0 -> IDLE.
  - ERR (1 cycle): done_o=1, err_o=1, err_idx_o=idx -> IDLE.
    - err_o and err_idx_o hold their values after ERR until the next accepted start.
- In WAIT, child_done_i bits for indices other than idx are ignored. Stale or early dones from other children have no effect.
- start_i while busy_o=1 is ignored; no queuing.
- start_i asserted in the DONE or ERR cycle is ignored. The earliest restart is the cycle after done_o.
- Timing:
  - A child that asserts done k cycles after its strobe cycle (k>=1) consumes 1+k cycles.
  - A full successful sequence ends with done_o at cycle c0+1+sum(1+k_i), where start_i is sampled at edge c0.
  - A timeout occurs after exactly TIMEOUT WAIT cycles without done. ERR is entered on the following edge.
- The wait counter needs width $clog2(TIMEOUT)+1 and must never wrap.
- N_CHILD=1: the sequence is LAUNCH -> WAIT -> DONE/ERR, with idx fixed at 0.

Test Plan:
1. Reset mid-WAIT on child 2 -> same cycle: busy_o=0, child_start_o=0, err_o=0. No done_o afterwards; a new start begins again at child 0.
2. Defaults, each child answers k=3 cycles after its strobe, start_i at cycle 0 -> child_start_o = 00001, 00010, 00100, 01000, 10000 at cycles 1, 5, 9, 13, 17 respectively. done_o=1 with err_o=0 at cycle 21; busy_o high for cycles 1-21.
3. Child 3 never answers, others k=1 -> after 16 WAIT cycles on child 3: done_o=1, err_o=1, err_idx_o=3. Child 4 is never strobed; err_idx_o still 3 ten cycles later.
4. child_done_i=11111 held constant, start -> each WAIT lasts 1 cycle and children are strobed every 2 cycles. done_o at cycle 11; an early done in a LAUNCH cycle does not skip that child's WAIT.
5. Child 0 answers exactly in its 16th WAIT cycle -> no error; sequence continues to child 1 (done beats timeout).
6. start_i pulsed during busy and during the done_o cycle -> ignored. Exactly one done_o per accepted start; an error from a prior run clears on the next accepted start.
